victim_cache_fa: RTL
====================

Name: victim_cache_fa

Overview:
- Fully-associative victim cache that sits behind the 32-line direct-mapped L1.
- Accepts lines evicted by the L1 (tag + 256-bit data).
- Answers L1 miss lookups by returning the stored line on memDataFromVictim one cycle later.
- A hit swaps the line back into the L1: the entry is invalidated, and the eviction caused by the refill can land in the freed slot.

Parameters:
- DEPTH, 8, number of line entries (power of two, 2..32).
- PTR_W, 3, log2(DEPTH); width of the replacement pointer.
- CNT_W, 16, width of the saturating hit/miss statistics counters.

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  synchronous active-high reset.
- lookupValid  in  1  L1 miss lookup request this cycle.
- lookupAddr  in  32  byte address; the line tag is lookupAddr[31:5].
- evictValid  in  1  L1 is pushing an evicted line this cycle.
- evictTag  in  27  line address [31:5] of the evicted line.
- evictData  in  256  evicted line contents.
- memDataFromVictim  out  256  returned line; all-zero unless victimHit.
- victimHit  out  1  one-cycle pulse: lookup hit, data valid.
- victimMiss  out  1  one-cycle pulse: lookup missed.
- occupancy  out  PTR_W+1  number of valid entries.
- hitCount  out  CNT_W  saturating lookup-hit count.
- missCount  out  CNT_W  saturating lookup-miss count.

Behaviour:
- Storage:
  - DEPTH entries, each holding valid, tag[26:0] and data[255:0].
  - A replacement pointer rp (PTR_W bits) gives FIFO replacement order.
- Reset (RST=1 at a CLK edge):
  - All valid bits are cleared, rp=0, and all outputs go to 0.
  - Reset mid-lookup discards the pending response: no hit or miss pulse follows.
  - Entry data need not be cleared.
- Lookup (latency 1):
  - With lookupValid=1 at edge N, all valid tags are compared with lookupAddr[31:5].
  - At edge N+1 the registered outputs are:
    - on hit: victimHit=1, memDataFromVictim = entry data, and the entry's valid bit is cleared;
    - on miss: victimMiss=1, memDataFromVictim=0.
  - Outputs return to 0 in the next cycle unless another lookup occurred.
  - Back-to-back lookups are supported, one per cycle.
- Eviction insert, evaluated at the same edge as the lookup. Slot selection in priority order:
  - (a) A valid entry with tag == evictTag is overwritten in place, so no duplicate tags ever exist.
  - (b) Else, if this cycle's lookup hits, the evicted line takes the hit slot (swap).
  - (c) Else, the lowest-index invalid entry is used.
  - (d) Else (cache full), entry rp is replaced and rp = (rp+1) mod DEPTH; rp wraps from DEPTH-1 to 0.
  - rp advances only in case (d).
- Simultaneous lookup and evict with the same tag:
  - The lookup reports a hit and memDataFromVictim = evictData (forwarded).
  - No entry is written for that line, and any stale entry with that tag is invalidated.
- occupancy:
  - Updated at the same edge as the lookup/evict that changes it.
  - A swap, i.e. hit plus insert into the freed slot, leaves occupancy unchanged.
  - occupancy never exceeds DEPTH.
- Counters:
  - hitCount increments on each hit and missCount on each miss.
  - Both hold at 2^CNT_W-1 once reached.
- lookupValid=0 with evictValid=0 leaves all state unchanged.

Test Plan:
- Reset, then lookup 0x00001240 -> next cycle victimMiss=1, memDataFromVictim=0, missCount=1, occupancy=0.
- Evict tag 0x0000092 with data 0xA5..A5, then lookup 0x00001244 -> next cycle victimHit=1, data 0xA5..A5, occupancy returns to 0, hitCount=1.
- Fill DEPTH+2 distinct tags T0..T9 (DEPTH=8):
  - T0 and T1 are replaced, so lookup(T0) misses and lookup(T9) hits;
  - rp=2 after the fills, and occupancy stays at 8.
- Same-cycle lookup hit on T3 plus evict of T20 -> T3 data returned, T20 lands in T3's slot, occupancy unchanged at 8, rp unchanged.
- Same-cycle lookup and evict of tag 0x1ABCDEF with data D -> victimHit with data D, no entry written, occupancy unchanged.
- Assert RST in the cycle after a lookup hit request -> no victimHit pulse follows, occupancy=0, and a subsequent lookup of the same tag misses.

Source files
------------

// File: rtl/victim_cache_fa.sv
// Fully-associative victim cache behind a direct-mapped L1: absorbs evicted lines and
// answers L1 miss lookups one cycle after the lookup is sampled.
module victim_cache_fa #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             lookupValid,
    input  logic [31:0]      lookupAddr,
    input  logic             evictValid,
    input  logic [26:0]      evictTag,
    input  logic [255:0]     evictData,
    output logic [255:0]     memDataFromVictim,
    output logic             victimHit,
    output logic             victimMiss,
    output logic [PTR_W:0]   occupancy,
    output logic [CNT_W-1:0] hitCount,
    output logic [CNT_W-1:0] missCount
);

    logic [DEPTH-1:0] r_valid;
    logic [26:0]      r_tag  [DEPTH];
    logic [255:0]     r_data [DEPTH];
    logic [PTR_W-1:0] r_rp;
    logic [PTR_W:0]   r_occ;
    logic             r_pend_vld;
    logic             r_pend_hit;
    logic [255:0]     r_pend_data;
    logic             r_hit;
    logic             r_miss;
    logic [255:0]     r_rdata;
    logic [CNT_W-1:0] r_hit_cnt;
    logic [CNT_W-1:0] r_miss_cnt;

    logic [26:0]      w_lk_tag;
    logic             w_fwd;
    logic             w_hit_any;
    logic             w_em_any;
    logic             w_free_any;
    logic             w_lk_hit;
    logic             w_do_ins;
    logic             w_adv_rp;
    logic [PTR_W-1:0] w_hit_idx;
    logic [PTR_W-1:0] w_em_idx;
    logic [PTR_W-1:0] w_free_idx;
    logic [PTR_W-1:0] w_ins_idx;
    logic [DEPTH-1:0] w_valid_nxt;
    logic [PTR_W:0]   w_occ_nxt;
    logic [255:0]     w_hit_data;

    always_comb begin
        w_lk_tag   = lookupAddr[31:5];
        w_fwd      = lookupValid && evictValid && (evictTag == w_lk_tag);
        w_hit_any  = 1'b0;
        w_hit_idx  = '0;
        w_em_any   = 1'b0;
        w_em_idx   = '0;
        w_free_any = 1'b0;
        w_free_idx = '0;
        // Descending scan so the lowest matching index is the one left standing.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_tag[i] == w_lk_tag)) begin
                w_hit_any = 1'b1;
                w_hit_idx = PTR_W'(i);
            end
            if (r_valid[i] && (r_tag[i] == evictTag)) begin
                w_em_any = 1'b1;
                w_em_idx = PTR_W'(i);
            end
            if (!r_valid[i]) begin
                w_free_any = 1'b1;
                w_free_idx = PTR_W'(i);
            end
        end

        w_lk_hit  = lookupValid && (w_fwd || w_hit_any);
        w_do_ins  = evictValid && !w_fwd;
        w_ins_idx = r_rp;
        w_adv_rp  = 1'b0;
        if (w_em_any) begin
            w_ins_idx = w_em_idx;
        end else if (lookupValid && w_hit_any) begin
            w_ins_idx = w_hit_idx;
        end else if (w_free_any) begin
            w_ins_idx = w_free_idx;
        end else begin
            w_adv_rp = w_do_ins;
        end

        // A forwarded lookup still kills any stale copy of the same tag.
        w_valid_nxt = r_valid;
        if (lookupValid && w_hit_any) w_valid_nxt[w_hit_idx] = 1'b0;
        if (w_do_ins) w_valid_nxt[w_ins_idx] = 1'b1;

        w_occ_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ_nxt = w_occ_nxt + {{PTR_W{1'b0}}, w_valid_nxt[i]};
        end

        w_hit_data = w_fwd ? evictData : r_data[w_hit_idx];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_valid     <= '0;
            r_rp        <= '0;
            r_occ       <= '0;
            r_pend_vld  <= 1'b0;
            r_pend_hit  <= 1'b0;
            r_pend_data <= '0;
            r_hit       <= 1'b0;
            r_miss      <= 1'b0;
            r_rdata     <= '0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
        end else begin
            r_valid     <= w_valid_nxt;
            r_occ       <= w_occ_nxt;
            if (w_adv_rp) r_rp <= r_rp + PTR_W'(1);
            r_pend_vld  <= lookupValid;
            r_pend_hit  <= w_lk_hit;
            r_pend_data <= w_lk_hit ? w_hit_data : '0;
            r_hit       <= r_pend_vld && r_pend_hit;
            r_miss      <= r_pend_vld && !r_pend_hit;
            r_rdata     <= r_pend_data;
            if (r_pend_vld && r_pend_hit && !(&r_hit_cnt)) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
            if (r_pend_vld && !r_pend_hit && !(&r_miss_cnt)) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
        end
    end

    // Line storage carries no reset; the valid bits alone qualify it.
    always_ff @(posedge CLK) begin
        if (w_do_ins) begin
            r_tag[w_ins_idx]  <= evictTag;
            r_data[w_ins_idx] <= evictData;
        end
    end

    assign memDataFromVictim = r_rdata;
    assign victimHit         = r_hit;
    assign victimMiss        = r_miss;
    assign occupancy         = r_occ;
    assign hitCount          = r_hit_cnt;
    assign missCount         = r_miss_cnt;

endmodule
